// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: WIDTH-bit a - b - b_in computed one 4-bit nibble
// per clock, LSB nibble first, with a start/busy/done handshake.
// Optional feature macro: OVF_DETECT_EN adds the signed-overflow output ovf.

// One nibble of the subtract chain: {brw_o, d_o} = a_i - b_i - brw_i in 5 bits.
module nibble_sub_cell (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       brw_i,
  output logic [3:0] d_o,
  output logic       brw_o
);
  logic [4:0] r;

  // The 5th bit of the widened result is the borrow out of this nibble.
  assign r = {1'b0, a_i} - {1'b0, b_i} - {4'b0, brw_i};
  assign {brw_o, d_o} = r;
endmodule

module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q;      // operand shift registers, nibble 0 at the bottom
  logic               brw_q;         // running borrow between nibbles
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   diff_q;        // result fills from the top and shifts down
  logic               bout_q;
  logic               busy_q;
  logic               done_q;
`ifdef OVF_DETECT_EN
  logic               a_msb_q, b_msb_q;
  logic               ovf_q;
`endif

  logic [3:0]         d4;
  logic               brw_d;
  logic               last_nib;

  // Current nibble always sits at the bottom of the operand shift registers.
  nibble_sub_cell u_cell (
    .a_i   (a_q[3:0]),
    .b_i   (b_q[3:0]),
    .brw_i (brw_q),
    .d_o   (d4),
    .brw_o (brw_d)
  );

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // Control FSM plus the serial datapath; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      idx_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OVF_DETECT_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= b_in;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef OVF_DETECT_EN
            // Sign bits are kept separately because the operand registers
            // are shifted away during the run.
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          // After NIBBLES shifts, nibble 0 has reached diff[3:0].
          diff_q <= {d4, diff_q[WIDTH-1:4]};
          a_q    <= {4'b0, a_q[WIDTH-1:4]};
          b_q    <= {4'b0, b_q[WIDTH-1:4]};
          brw_q  <= brw_d;
          idx_q  <= idx_q + 1'b1;
          if (last_nib) begin
            bout_q  <= brw_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef OVF_DETECT_EN
            // d4[3] is the new result MSB.
            ovf_q   <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d4[3]);
`endif
          end
        end
        S_DONE: begin
          // done pulse is exactly this one cycle; start is not looked at here.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = bout_q;
`ifdef OVF_DETECT_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16): directed cases
// followed by random operations checked against an arithmetic reference.
module tb_nibble_serial_subtractor;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst, start, b_in;
  logic [W-1:0] a, b;
  logic         busy, done, b_out;
  logic [W-1:0] diff;
`ifdef OVF_DETECT_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef OVF_DETECT_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbi,
                         output logic [W-1:0] ed, output logic eb, output logic eo);
    longint d, sa, sb, sd;
    longint full;
    d    = longint'(ra) - longint'(rb) - longint'(rbi);
    eb   = (d < 0);
    full = d + (longint'(1) << W);
    ed   = full[W-1:0];
    sa   = ra[W-1] ? longint'(ra) - (longint'(1) << W) : longint'(ra);
    sb   = rb[W-1] ? longint'(rb) - (longint'(1) << W) : longint'(rb);
    sd   = sa - sb - longint'(rbi);
    eo   = (sd < -(longint'(1) << (W-1))) || (sd > (longint'(1) << (W-1)) - 1);
  endtask

  // Entered at the negedge of the first RUN cycle; leaves at a negedge in IDLE.
  task automatic finish_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                           input logic obi, input logic scramble);
    logic [W-1:0] ed;
    logic eb, eo;
    ref_sub(oa, ob, obi, ed, eb, eo);
    for (int k = 0; k < N; k++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      end
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(b_out), 32'(eb));
`ifdef OVF_DETECT_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_diff_held"}, 32'(diff), 32'(ed));
    check({tag, "_bout_held"}, 32'(b_out), 32'(eb));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic obi);
    a = oa; b = ob; b_in = obi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op(tag, oa, ob, obi, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(b_out), 32'd0);
`ifdef OVF_DETECT_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_op("t1", 16'h1234, 16'h0234, 1'b0);
    run_op("t2", 16'h0000, 16'h0001, 1'b0);
    run_op("t3", 16'h8000, 16'h0000, 1'b1);
    run_op("t_ff", 16'hFFFF, 16'hFFFF, 1'b1);
    run_op("t_pos_ovf", 16'h7FFF, 16'hFFFF, 1'b0);

    // Start held high and operands toggling while busy: must be ignored.
    a = 16'h1234; b = 16'h0234; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("t4_busy", 32'(busy), 32'd1);
      a = k[0] ? 16'h0000 : 16'hFFFF;
      b = ~a;
      b_in = k[0];
      @(negedge clk);
    end
    check("t4_done", 32'(done), 32'd1);
    check("t4_diff", 32'(diff), 32'h1000);
    check("t4_bout", 32'(b_out), 32'd0);
    a = 16'h00F0; b = 16'h000F; b_in = 1'b1;
    @(negedge clk);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_done", 32'(done), 32'd0);
    check("t4_idle_diff", 32'(diff), 32'h1000);
    @(negedge clk);
    start = 1'b0;
    finish_op("t4_next", 16'h00F0, 16'h000F, 1'b1, 1'b1);

    // Reset during the second RUN cycle aborts the operation.
    a = 16'h0005; b = 16'h0003; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_diff", 32'(diff), 32'd0);
    check("t5_bout", 32'(b_out), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      @(negedge clk);
      check("t5_no_done", 32'(done), 32'd0);
      check("t5_idle", 32'(busy), 32'd0);
    end

    // rst and start together: rst wins.
    rst = 1'b1; start = 1'b1; a = 16'h4321; b = 16'h1111;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", 32'(busy), 32'd0);

    // Random operations.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic rbi;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      if (i % 16 == 0) rb = ra;
      run_op("rand", ra, rb, rbi);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
